// File: rtl/aes_round_sequencer.sv
// Iterative AES encryption round controller: owns the 128-bit cipher state and
// steps an external combinational round datapath once per cycle over NR rounds.
module aes_round_sequencer #(
  parameter int KEY_BITS = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic [3:0]   key_idx,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic [127:0] rnd_in,
  output logic         rnd_last,
  input  logic [127:0] rnd_out,
  output logic         busy
);

  localparam int NR = KEY_BITS / 32 + 6;
  localparam logic [3:0] NR_IDX = 4'(NR);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_round_sequencer: KEY_BITS must be 128, 192 or 256");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t       fsm, fsm_nxt;
  logic [127:0] st, st_nxt;
  logic [3:0]   rnd, rnd_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm <= IDLE;
      st  <= '0;
      rnd <= '0;
    end else begin
      fsm <= fsm_nxt;
      st  <= st_nxt;
      rnd <= rnd_nxt;
    end
  end

  always_comb begin
    fsm_nxt   = fsm;
    st_nxt    = st;
    rnd_nxt   = rnd;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_block = '0;
    key_idx   = '0;
    rnd_last  = 1'b0;
    case (fsm)
      IDLE: begin
        // Round key 0 must be present to perform the initial AddRoundKey.
        in_ready = key_valid;
        if (in_valid && key_valid) begin
          st_nxt  = in_block ^ key_in;
          rnd_nxt = 4'd1;
          fsm_nxt = ROUND;
        end
      end
      ROUND: begin
        key_idx  = rnd;
        rnd_last = (rnd == NR_IDX);
        if (key_valid) begin
          st_nxt = rnd_out;
          if (rnd == NR_IDX) fsm_nxt = DONE;
          else               rnd_nxt = rnd + 4'd1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        out_block = st;
        key_idx   = NR_IDX;
        if (out_ready) begin
          fsm_nxt = IDLE;
          rnd_nxt = '0;
        end
      end
      default: begin
        fsm_nxt = IDLE;
        rnd_nxt = '0;
      end
    endcase
  end

  assign rnd_in = st;
  assign busy   = (fsm != IDLE);

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: drives an AES-128 and an AES-256 instance with a
// behavioural key schedule and round datapath, checking against a full-cipher model.
module tb_aes_round_sequencer;

  typedef logic [14:0][127:0] rkeys_t;

  logic clk = 1'b0;
  logic rst;
  logic         iv   [2];
  logic         ordy [2];
  logic         kv   [2];
  logic [127:0] inb  [2];
  rkeys_t       rk   [2];
  wire          ird   [2];
  wire          ov    [2];
  wire          rlast [2];
  wire          bsy   [2];
  wire  [127:0] outb  [2];
  wire  [127:0] kin   [2];
  wire  [127:0] rin   [2];
  wire  [127:0] rout  [2];
  wire  [3:0]   kidx  [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic hi;
    a = a_in; b = b_in; p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b  = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv, base, e;
    inv = 8'h01; base = x; e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) inv = gmul(inv, base);
      base = gmul(base, base);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [7:0] a [16];
    logic [7:0] t [16];
    logic [7:0] b0, b1, b2, b3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) a[i] = sbox(s[127-8*i -: 8]);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) t[r+4*c] = a[r+4*((c+r)%4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        b0 = t[4*c]; b1 = t[4*c+1]; b2 = t[4*c+2]; b3 = t[4*c+3];
        t[4*c]   = gmul(b0, 8'd2) ^ gmul(b1, 8'd3) ^ b2 ^ b3;
        t[4*c+1] = b0 ^ gmul(b1, 8'd2) ^ gmul(b2, 8'd3) ^ b3;
        t[4*c+2] = b0 ^ b1 ^ gmul(b2, 8'd2) ^ gmul(b3, 8'd3);
        t[4*c+3] = gmul(b0, 8'd3) ^ b1 ^ b2 ^ gmul(b3, 8'd2);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    return o ^ k;
  endfunction

  // Key is left-aligned in 256 bits; nk is the key length in 32-bit words.
  function automatic rkeys_t expand(input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rkeys_t      res;
    res = '0; rc = 8'h01;
    for (int i = 0; i < 60; i++) w[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nk+7); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = gmul(rc, 8'd2);
      end else if (nk > 6 && i % nk == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int r = 0; r < nk+7; r++) res[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return res;
  endfunction

  function automatic logic [127:0] model_encrypt(input logic [127:0] pt, input logic [255:0] key,
                                                 input int nk);
    rkeys_t ks;
    logic [127:0] s;
    ks = expand(key, nk);
    s  = pt ^ ks[0];
    for (int r = 1; r <= nk+6; r++) s = aes_round(s, ks[r], r == nk+6);
    return s;
  endfunction

  assign kin[0]  = rk[0][kidx[0]];
  assign kin[1]  = rk[1][kidx[1]];
  assign rout[0] = aes_round(rin[0], kin[0], rlast[0]);
  assign rout[1] = aes_round(rin[1], kin[1], rlast[1]);

  aes_round_sequencer #(.KEY_BITS(128)) u128 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ird[0]), .in_block(inb[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_block(outb[0]), .key_idx(kidx[0]),
    .key_in(kin[0]), .key_valid(kv[0]), .rnd_in(rin[0]), .rnd_last(rlast[0]),
    .rnd_out(rout[0]), .busy(bsy[0])
  );

  aes_round_sequencer #(.KEY_BITS(256)) u256 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ird[1]), .in_block(inb[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_block(outb[1]), .key_idx(kidx[1]),
    .key_in(kin[1]), .key_valid(kv[1]), .rnd_in(rin[1]), .rnd_last(rlast[1]),
    .rnd_out(rout[1]), .busy(bsy[1])
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts and ends just after a falling edge. Stalls key_valid for len cycles at
  // rounds s1/s2 (0 = none), holds out_ready low for hold cycles in DONE, and can
  // present the next block during that backpressure.
  task automatic run(input int d, input logic [127:0] pt, input logic [255:0] key,
                     input int s1, input int s2, input int len, input int hold,
                     input bit nxt_en, input logic [127:0] nxt_pt,
                     input logic [127:0] exp_ct, input string tag);
    int nr, r, s, lat, waitc, extra;
    logic [127:0] held;
    nr = (d == 1) ? 14 : 10;
    rk[d] = expand(key, (d == 1) ? 8 : 4);
    inb[d] = pt; iv[d] = 1'b1; kv[d] = 1'b1;
    #1;
    waitc = 0;
    while (!ird[d] && waitc < 20) begin
      @(negedge clk); #1; waitc++;
    end
    chk({tag, "_accept"}, 128'(ird[d]), 128'd1);
    chk({tag, "_kidx0"}, 128'(kidx[d]), 128'd0);
    @(negedge clk);
    iv[d] = 1'b0;
    #1;
    r = 1; s = 0; lat = 0; held = '0;
    while (!ov[d] && lat < 100) begin
      chk({tag, "_kidx"}, 128'(kidx[d]), 128'(r));
      chk({tag, "_rlast"}, 128'(rlast[d]), 128'(r == nr));
      if ((r == s1 || r == s2) && s < len) begin
        kv[d] = 1'b0; s++; held = rin[d];
      end else begin
        kv[d] = 1'b1;
      end
      @(negedge clk); #1; lat++;
      if (!kv[d]) chk({tag, "_stall_hold"}, rin[d], held);
      else begin r++; s = 0; end
    end
    kv[d] = 1'b1;
    extra = ((s1 >= 1) ? len : 0) + ((s2 >= 1 && s2 != s1) ? len : 0);
    chk({tag, "_latency"}, 128'(lat), 128'(nr + extra));
    chk({tag, "_done_kidx"}, 128'(kidx[d]), 128'(nr));
    chk({tag, "_done_rlast"}, 128'(rlast[d]), 128'd0);
    chk({tag, "_ct"}, outb[d], exp_ct);
    if (nxt_en) begin inb[d] = nxt_pt; iv[d] = 1'b1; end
    if (hold > 0) ordy[d] = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk); #1;
      chk({tag, "_bp_valid"}, 128'(ov[d]), 128'd1);
      chk({tag, "_bp_stable"}, outb[d], exp_ct);
      chk({tag, "_bp_inready"}, 128'(ird[d]), 128'd0);
    end
    ordy[d] = 1'b1;
    #1;
    @(negedge clk); #1;
    chk({tag, "_hs_valid"}, 128'(ov[d]), 128'd0);
    chk({tag, "_hs_idle"}, 128'(bsy[d]), 128'd0);
    if (nxt_en) chk({tag, "_hs_next_ready"}, 128'(ird[d]), 128'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] fips_pt, fips_ct, c3_pt, c3_ct, pt, pt2;
    logic [255:0] fips_key, c3_key, key;
    int s1, s2, len, hold;
    fips_pt  = 128'h3243f6a8885a308d313198a2e0370734;
    fips_ct  = 128'h3925841d02dc09fbdc118597196a0b32;
    fips_key = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    c3_pt    = 128'h00112233445566778899aabbccddeeff;
    c3_ct    = 128'h8ea2b7ca516745bfeafc49904b496089;
    c3_key   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    rst = 1'b1;
    iv[0] = 1'b0; iv[1] = 1'b0; ordy[0] = 1'b1; ordy[1] = 1'b1;
    kv[0] = 1'b0; kv[1] = 1'b1; inb[0] = '0; inb[1] = '0;
    rk[0] = expand(fips_key, 4); rk[1] = expand(c3_key, 8);
    #1;
    chk("rst_inready", 128'(ird[0]), 128'd0);
    chk("rst_outvalid", 128'(ov[0]), 128'd0);
    chk("rst_busy", 128'(bsy[0]), 128'd0);
    chk("rst_kidx", 128'(kidx[0]), 128'd0);
    chk("rst_outblock", outb[0], 128'd0);
    chk("rst_rndin", rin[0], 128'd0);
    chk("rst_rlast", 128'(rlast[0]), 128'd0);
    kv[0] = 1'b1; #1;
    chk("rst_inready_kv", 128'(ird[0]), 128'd1);
    kv[0] = 1'b0;

    // Block offered while key_valid is low must wait.
    @(negedge clk);
    rst = 1'b0; inb[0] = fips_pt; iv[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("nokey_busy", 128'(bsy[0]), 128'd0);
      chk("nokey_inready", 128'(ird[0]), 128'd0);
    end

    run(0, fips_pt, fips_key, 0, 0, 0, 0, 1'b0, '0, fips_ct, "fipsB");
    run(0, fips_pt, fips_key, 4, 10, 3, 0, 1'b0, '0, fips_ct, "fipsB_stall");

    key = {$urandom, $urandom, $urandom, $urandom, 128'h0};
    pt  = {$urandom, $urandom, $urandom, $urandom};
    pt2 = {$urandom, $urandom, $urandom, $urandom};
    run(0, pt, key, 0, 0, 0, 5, 1'b1, pt2, model_encrypt(pt, key, 4), "bp_first");
    run(0, pt2, key, 0, 0, 0, 0, 1'b0, '0, model_encrypt(pt2, key, 4), "bp_second");

    run(1, c3_pt, c3_key, 0, 0, 0, 0, 1'b0, '0, c3_ct, "fipsC3");
    key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    pt  = {$urandom, $urandom, $urandom, $urandom};
    run(1, pt, key, 14, 7, 2, 2, 1'b0, '0, model_encrypt(pt, key, 8), "rand256");

    // Asynchronous reset in round 5 discards the block.
    key = {$urandom, $urandom, $urandom, $urandom, 128'h0};
    rk[0] = expand(key, 4); inb[0] = fips_pt; iv[0] = 1'b1; kv[0] = 1'b1;
    @(negedge clk); iv[0] = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("midrst_kidx5", 128'(kidx[0]), 128'd5);
    #2 rst = 1'b1; #1;
    chk("midrst_busy", 128'(bsy[0]), 128'd0);
    chk("midrst_outvalid", 128'(ov[0]), 128'd0);
    chk("midrst_kidx", 128'(kidx[0]), 128'd0);
    chk("midrst_rndin", rin[0], 128'd0);
    @(negedge clk); rst = 1'b0; #1;
    chk("midrst_after_busy", 128'(bsy[0]), 128'd0);
    pt = {$urandom, $urandom, $urandom, $urandom};
    run(0, pt, key, 0, 0, 0, 0, 1'b0, '0, model_encrypt(pt, key, 4), "after_rst");

    for (int n = 0; n < 6; n++) begin
      key  = {$urandom, $urandom, $urandom, $urandom, 128'h0};
      pt   = {$urandom, $urandom, $urandom, $urandom};
      s1   = $urandom_range(0, 10);
      s2   = $urandom_range(0, 10);
      len  = $urandom_range(0, 3);
      hold = $urandom_range(0, 3);
      run(0, pt, key, s1, s2, len, hold, 1'b0, '0, model_encrypt(pt, key, 4), "rand128");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
